// File: rtl/radix2_pair_buffer_if.sv
// Sample stream bus for one radix-2 DIF pair-forming stage: live input
// samples in, (x1, x2, twiddle index) pairs out.
interface radix2_pair_buffer_if #(
    parameter int FLOAT_LEN = 32,
    parameter int ADDR_LEN  = 2
);
    logic [2*FLOAT_LEN-1:0] data_in;
    logic                   data_in_valid;
    logic [2*FLOAT_LEN-1:0] data_out1;
    logic [2*FLOAT_LEN-1:0] data_out2;
    logic                   data_out_valid;
    logic [ADDR_LEN-1:0]    tf_idx;
    logic                   block_last;
    logic                   overrun;

    // Upstream/consumer side: drives samples, observes pairs.
    modport master (
        output data_in, data_in_valid,
        input  data_out1, data_out2, data_out_valid, tf_idx, block_last, overrun
    );

    // Pair buffer side: consumes samples, produces pairs.
    modport slave (
        input  data_in, data_in_valid,
        output data_out1, data_out2, data_out_valid, tf_idx, block_last, overrun
    );
endinterface

// File: rtl/radix2_pair_buffer.sv
// Delay-line pair former for one radix-2 DIF butterfly stage.
// The first DEPTH valid samples of each 2*DEPTH block are stored; each of the
// next DEPTH valid samples is emitted together with its stored partner one
// clock later. A valid-sample counter alone sequences fill and pair phases,
// so gaps in data_in_valid of any length leave the pairing intact.
module radix2_pair_buffer #(
    parameter int FLOAT_LEN = 32,
    parameter int ADDR_LEN  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    radix2_pair_buffer_if.slave   bus
);
    localparam int DEPTH = 2 ** ADDR_LEN;
    localparam int WIDTH = 2 * FLOAT_LEN;

    // Phase of the current block, taken directly from the counter MSB.
    typedef enum logic {
        FILL = 1'b0,
        PAIR = 1'b1
    } state_t;

    logic [ADDR_LEN:0]   cnt_r;
    logic [WIDTH-1:0]    mem_r [DEPTH];
    logic [WIDTH-1:0]    data_out1_r;
    logic [WIDTH-1:0]    data_out2_r;
    logic                data_out_valid_r;
    logic [ADDR_LEN-1:0] tf_idx_r;
    logic                block_last_r;

    state_t              state_s;
    logic [ADDR_LEN-1:0] k_s;

    assign state_s = state_t'(cnt_r[ADDR_LEN]);
    assign k_s     = cnt_r[ADDR_LEN-1:0];

    // First-half samples go into the delay memory; storage is never cleared.
    always_ff @(posedge clk) begin
        if (rst && bus.data_in_valid && (state_s == FILL)) begin
            mem_r[k_s] <= bus.data_in;
        end
    end

    // Counter sequencing plus registered pair outputs; only PAIR-phase
    // samples touch the data outputs, so a fill write never disturbs them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_r            <= {(ADDR_LEN+1){1'b0}};
            data_out1_r      <= {WIDTH{1'b0}};
            data_out2_r      <= {WIDTH{1'b0}};
            data_out_valid_r <= 1'b0;
            tf_idx_r         <= {ADDR_LEN{1'b0}};
            block_last_r     <= 1'b0;
        end else if (bus.data_in_valid) begin
            // Natural wrap of the ADDR_LEN+1 bit counter is the modulo 2*DEPTH.
            cnt_r <= cnt_r + {{ADDR_LEN{1'b0}}, 1'b1};
            case (state_s)
                FILL: begin
                    data_out_valid_r <= 1'b0;
                end
                PAIR: begin
                    data_out1_r      <= mem_r[k_s];
                    data_out2_r      <= bus.data_in;
                    tf_idx_r         <= k_s;
                    block_last_r     <= (k_s == {ADDR_LEN{1'b1}});
                    data_out_valid_r <= 1'b1;
                end
                default: begin
                    data_out_valid_r <= 1'b0;
                end
            endcase
        end else begin
            data_out_valid_r <= 1'b0;
        end
    end

    assign bus.data_out1      = data_out1_r;
    assign bus.data_out2      = data_out2_r;
    assign bus.data_out_valid = data_out_valid_r;
    assign bus.tf_idx         = tf_idx_r;
    assign bus.block_last     = block_last_r;
    // Reserved for a future ready/backpressure port.
    assign bus.overrun        = 1'b0;
endmodule
